eth_rx_addr_filter: RTL and testbench
=====================================

# eth_rx_addr_filter

Receive-side destination-address filter between the 1G MAC's byte-wide RX AXI-Stream output and the Ethernet DMA/host interface. It buffers each frame's 6-byte destination MAC and decides whether to forward or discard the frame. Frames are accepted if they are unicast to the local address, broadcast, multicast (when enabled), or any frame when promiscuous mode is on. Pass and drop events are counted for driver statistics.

## Interface
- DROP_COUNT_WIDTH, 16, width of the saturating frame counters
- clock125  in  1  125 MHz clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- mac_addr  in  48  local MAC; [47:40] is the first byte on the wire
- promiscuous  in  1  accept every frame of 6 or more bytes
- accept_multicast  in  1  accept frames with bit 0 of destination byte 0 set
- s_axis_tdata  in  8  frame byte from the MAC
- s_axis_tvalid  in  1  input byte valid
- s_axis_tready  out  1  input byte accepted
- s_axis_tlast  in  1  last byte of the frame
- s_axis_tuser  in  1  bad-frame flag, meaningful only with tlast
- m_axis_tdata  out  8  forwarded byte
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last byte of the forwarded frame
- m_axis_tuser  out  1  bad-frame flag, forwarded on the last byte
- pass_count  out  DROP_COUNT_WIDTH  frames forwarded
- drop_count  out  DROP_COUNT_WIDTH  frames discarded, including runts

## Operation
- Handshake: a byte transfers on a cycle where tvalid && tready. tvalid and data hold until accepted; no combinational path from s_axis_tvalid to s_axis_tready.
- State HEADER:
  - s_axis_tready=1, m_axis_tvalid=0.
  - Accepted bytes go into hdr[0..5]; 3-bit count idx.
  - tlast accepted with idx<5 is a runt: discard, drop_count+1, idx=0, stay in HEADER.
  - Decision on the 6th-byte handshake:
    - Evaluated on {hdr[0..4], s_axis_tdata}.
    - Accept if promiscuous, or dest==mac_addr, or dest==48'hFFFF_FFFF_FFFF, or (accept_multicast && hdr[0][0]).
    - Accept goes to FLUSH, reject goes to DROP.
  - If the 6th byte also carries tlast: accept goes to FLUSH with a last-byte flag; reject counts a drop and returns to HEADER.
- State FLUSH:
  - s_axis_tready=0; m_axis replays hdr[0..5] in order.
  - m_axis_tlast=0, except on byte 5 when the last-byte flag is set; then m_axis_tuser equals the captured tuser.
  - After byte 5 handshakes: PASS, or HEADER when the flag is set (pass_count+1).
- State PASS:
  - m_axis_tdata/tlast/tuser and m_axis_tvalid follow s_axis combinationally; s_axis_tready=m_axis_tready.
  - On the tlast handshake: pass_count+1, go to HEADER, idx=0.
- State DROP:
  - s_axis_tready=1, m_axis_tvalid=0.
  - On the tlast handshake: drop_count+1, go to HEADER.
- tuser does not affect the filter decision; bad frames are forwarded with the flag intact.
- mac_addr, promiscuous and accept_multicast are sampled only at decision time. Changes during a frame do not affect that frame.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (reset_n=0 at a clock edge):
  - Next cycle: state HEADER, idx=0, counters 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
  - s_axis_tready=0 while reset_n=0 and 1 afterwards.
- Reset mid-frame abandons the frame with no count. The MAC shares reset_n, so the next input byte is a frame start.
- Latency: if the 6th byte is accepted at edge N, m_axis_tvalid=1 with hdr[0] in cycle N+1.
- With m_axis_tready=1 throughout, FLUSH lasts 6 cycles and the input stalls for those 6 cycles. The 7th byte then passes with zero added latency.
- Back-to-back frames: the first byte of the next frame is accepted in the cycle after the previous tlast handshake.
- Throughput: one byte per cycle in HEADER, PASS and DROP.

## Test plan
- Unicast match: mac_addr=02:00:00:00:00:01, 64-byte frame to that destination, m_axis_tready=1.
  - All 64 bytes out in order; tlast on byte 63; first output at N+1.
  - pass_count=1, drop_count=0.
- Filtering: frames to 02:00:00:00:00:02, FF:FF:FF:FF:FF:FF and 01:00:5E:00:00:01 with accept_multicast=0, promiscuous=0.
  - Only the broadcast frame is forwarded; drop_count=2.
  - Repeat with promiscuous=1: all three forwarded.
- Runt and exact-6 frames:
  - 4-byte frame gives no output, drop_count+1.
  - 6-byte broadcast frame with tuser=1: 6 bytes out, tlast and tuser=1 on byte 5.
- Backpressure: m_axis_tready toggles randomly on a 100-byte matching frame.
  - Byte-exact output; s_axis_tready=0 throughout FLUSH.
  - No byte lost or duplicated.
- Reset mid-frame: reset_n=0 for 1 cycle after byte 20 of a passing frame.
  - Counters read 0, m_axis_tvalid=0.
  - The next frame is filtered correctly.
- Saturation: DROP_COUNT_WIDTH=2, 5 rejected frames → drop_count=3.

Source files
------------

// File: rtl/eth_rx_addr_filter.sv
`timescale 1ns/1ps
// eth_rx_addr_filter
// Receive-side destination-address filter for a byte-wide AXI-Stream path.
// The first six bytes of each frame (the destination MAC) are held back. On
// the sixth byte the filter decides to forward or discard the frame. Forwarded
// frames replay the held header and then pass the rest straight through.
// Ports:
//   clock125, reset_n        clock and synchronous active-low reset
//   mac_addr                 local MAC, [47:40] is the first byte on the wire
//   promiscuous              accept any frame of 6 or more bytes
//   accept_multicast         accept frames whose first destination byte has bit 0 set
//   s_axis_*                 input stream from the MAC (tdata/tvalid/tready/tlast/tuser)
//   m_axis_*                 filtered output stream to the DMA/host side
//   pass_count, drop_count   saturating frame statistics (runts count as drops)
module eth_rx_addr_filter #(
  parameter int unsigned DROP_COUNT_WIDTH = 16
) (
  input  logic                        clock125,
  input  logic                        reset_n,
  input  logic [47:0]                 mac_addr,
  input  logic                        promiscuous,
  input  logic                        accept_multicast,
  input  logic [7:0]                  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tuser,
  output logic [7:0]                  m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  output logic [DROP_COUNT_WIDTH-1:0] pass_count,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {HEADER, FLUSH, PASS, DROP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  // Header held as a byte shift register: byte 0 ends up in [47:40]. During
  // FLUSH it is rotated left one byte per handshake so the next byte to send
  // is always in [47:40], avoiding a 6:1 read mux.
  logic [47:0] hdr, hdr_nxt;
  logic        last_flag, last_flag_nxt;
  logic        user_cap, user_cap_nxt;
  logic        pass_inc, drop_inc;
  logic [47:0] dest;
  logic        accept;

  // At the 6th byte hdr[39:0] holds bytes 0..4; the 6th comes from the bus.
  assign dest   = {hdr[39:0], s_axis_tdata};
  assign accept = promiscuous || (dest == mac_addr) || (dest == 48'hFFFF_FFFF_FFFF) ||
                  (accept_multicast && hdr[32]);

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    hdr_nxt       = hdr;
    last_flag_nxt = last_flag;
    user_cap_nxt  = user_cap;
    pass_inc      = 1'b0;
    drop_inc      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;

    case (state)
      HEADER: begin
        s_axis_tready = reset_n;
        if (s_axis_tvalid && reset_n) begin
          hdr_nxt = {hdr[39:0], s_axis_tdata};
          if (idx == 3'd5) begin
            idx_nxt = '0;
            if (accept) begin
              state_nxt     = FLUSH;
              last_flag_nxt = s_axis_tlast;
              user_cap_nxt  = s_axis_tlast && s_axis_tuser;
            end else if (s_axis_tlast) begin
              drop_inc = 1'b1;
            end else begin
              state_nxt = DROP;
            end
          end else if (s_axis_tlast) begin
            drop_inc = 1'b1;
            idx_nxt  = '0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end

      FLUSH: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr[47:40];
        if (idx == 3'd5 && last_flag) begin
          m_axis_tlast = 1'b1;
          m_axis_tuser = user_cap;
        end
        if (m_axis_tready) begin
          hdr_nxt = {hdr[39:0], hdr[47:40]};
          if (idx == 3'd5) begin
            idx_nxt = '0;
            if (last_flag) begin
              pass_inc  = 1'b1;
              state_nxt = HEADER;
            end else begin
              state_nxt = PASS;
            end
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end

      PASS: begin
        s_axis_tready = reset_n && m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pass_inc  = 1'b1;
          state_nxt = HEADER;
          idx_nxt   = '0;
        end
      end

      DROP: begin
        s_axis_tready = reset_n;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = HEADER;
        end
      end

      default: state_nxt = HEADER;
    endcase
  end

  always_ff @(posedge clock125) begin
    if (!reset_n) begin
      state      <= HEADER;
      idx        <= '0;
      hdr        <= '0;
      last_flag  <= 1'b0;
      user_cap   <= 1'b0;
      pass_count <= '0;
      drop_count <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      hdr       <= hdr_nxt;
      last_flag <= last_flag_nxt;
      user_cap  <= user_cap_nxt;
      if (pass_inc && pass_count != '1)
        pass_count <= pass_count + DROP_COUNT_WIDTH'(1);
      if (drop_inc && drop_count != '1)
        drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
`timescale 1ns/1ps
// Testbench for eth_rx_addr_filter: frame-level reference model with an
// expected-output queue, plus a second instance with 2-bit counters that
// receives identical stimulus for counter saturation.
module tb_eth_rx_addr_filter;

  logic        clk = 1'b0;
  always #4 clk = ~clk;

  logic        reset_n;
  logic [47:0] mac_addr;
  logic        promiscuous, accept_multicast;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic        m_tready;

  logic        s_tready, m_tvalid, m_tlast, m_tuser;
  logic [7:0]  m_tdata;
  logic [15:0] pass_count, drop_count;

  logic        sat_s_tready, sat_m_tvalid, sat_m_tlast, sat_m_tuser;
  logic [7:0]  sat_m_tdata;
  logic [1:0]  sat_pass, sat_drop;

  eth_rx_addr_filter #(.DROP_COUNT_WIDTH(16)) u_dut (
    .clock125(clk), .reset_n(reset_n), .mac_addr(mac_addr),
    .promiscuous(promiscuous), .accept_multicast(accept_multicast),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .pass_count(pass_count), .drop_count(drop_count));

  eth_rx_addr_filter #(.DROP_COUNT_WIDTH(2)) u_sat (
    .clock125(clk), .reset_n(reset_n), .mac_addr(mac_addr),
    .promiscuous(promiscuous), .accept_multicast(accept_multicast),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(sat_s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(sat_m_tdata), .m_axis_tvalid(sat_m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(sat_m_tlast), .m_axis_tuser(sat_m_tuser),
    .pass_count(sat_pass), .drop_count(sat_drop));

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         pos;
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mdl_pass = 0;
  int         mdl_drop = 0;
  logic       bp_mode = 1'b0;
  logic       gap_mode = 1'b0;
  logic       scramble = 1'b0;
  logic [7:0] fr [0:255];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output checker: every output handshake must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n && m_tvalid && m_tready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got byte %0h with no byte expected", m_tdata);
      end else begin
        e = expq.pop_front();
        chk("out_byte", {61'd0, m_tlast, m_tuser, m_tdata} >> 0,
                        {54'd0, e.last, e.user, e.data});
        chk("sat_out_byte", {53'd0, sat_m_tvalid, sat_m_tlast, sat_m_tuser, sat_m_tdata},
                            {53'd0, 1'b1, e.last, e.user, e.data});
        if (e.pos < 6) begin
          chk("flush_stall", {63'd0, s_tready}, 64'd0);
          chk("sat_flush_stall", {63'd0, sat_s_tready}, 64'd0);
        end
      end
    end
  end

  // Downstream ready: random in backpressure mode, otherwise always ready.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] d, input logic l, input logic u, output logic ok);
    int t;
    if (gap_mode) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 1000) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      t++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_timeout: got no s_axis_tready expected handshake within 1000 cycles");
    end
  endtask

  task automatic make_frame(input logic [47:0] dest, input int len);
    for (int i = 0; i < 6; i++) fr[i] = dest[47-8*i -: 8];
    for (int i = 6; i < len; i++) fr[i] = 8'($urandom);
  endtask

  // Sends the first 'cut' bytes of a 'len'-byte frame held in fr[].
  // The frame is only counted by the model if it is sent completely.
  task automatic send_frame(input int len, input int cut, input logic user);
    logic [47:0] dest;
    logic        acc, ok;
    int          n_out;
    exp_t        x;
    dest  = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
    acc   = (len >= 6) && (promiscuous || dest == mac_addr ||
             dest == 48'hFFFF_FFFF_FFFF || (accept_multicast && fr[0][0]));
    n_out = (cut < len) ? cut : len;
    if (acc) begin
      for (int i = 0; i < n_out; i++) begin
        x.data = fr[i];
        x.last = (i == len - 1);
        x.user = (i == len - 1) ? user : 1'b0;
        x.pos  = i;
        expq.push_back(x);
      end
    end
    if (cut >= len) begin
      if (acc) mdl_pass++;
      else     mdl_drop++;
    end
    for (int i = 0; i < n_out; i++) begin
      send_byte(fr[i], (i == len - 1), (i == len - 1) ? user : 1'b0, ok);
      if (!ok) break;
      if (i == 5 && acc)
        chk("first_out_latency", {55'd0, m_tvalid, m_tdata}, {55'd0, 1'b1, fr[0]});
      if (i == 5 && scramble) begin
        promiscuous      = 1'($urandom_range(0, 1));
        accept_multicast = 1'($urandom_range(0, 1));
        mac_addr         = {16'($urandom), 32'($urandom)};
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() > 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (expq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d bytes still pending expected 0", expq.size());
      expq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_pass"}, 64'(pass_count), 64'(mdl_pass));
    chk({tag, "_drop"}, 64'(drop_count), 64'(mdl_drop));
    chk({tag, "_sat_pass"}, 64'(sat_pass), 64'((mdl_pass > 3) ? 3 : mdl_pass));
    chk({tag, "_sat_drop"}, 64'(sat_drop), 64'((mdl_drop > 3) ? 3 : mdl_drop));
  endtask

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;

  initial begin
    logic [47:0] dests [0:2];
    logic [47:0] d;
    int          len;
    dests[0] = OTHER;
    dests[1] = BCAST;
    dests[2] = MCAST;

    reset_n = 1'b0;
    mac_addr = LOCAL;
    promiscuous = 1'b0;
    accept_multicast = 1'b0;
    s_tdata = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s_tready_low", {63'd0, s_tready}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("reset_s_tready_high", {63'd0, s_tready}, 64'd1);
    chk("reset_m_out", {53'd0, m_tvalid, m_tlast, m_tuser, m_tdata}, 64'd0);
    chk("reset_pass", 64'(pass_count), 64'd0);
    chk("reset_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;

    // Unicast match, 64 bytes.
    make_frame(LOCAL, 64);
    send_frame(64, 64, 1'b0);
    drain();
    check_counts("unicast");
    chk("unicast_pass_lit", 64'(pass_count), 64'd1);
    chk("unicast_drop_lit", 64'(drop_count), 64'd0);

    // Filtering without and with promiscuous mode.
    for (int i = 0; i < 3; i++) begin
      make_frame(dests[i], 60);
      send_frame(60, 60, 1'b0);
      drain();
    end
    check_counts("filter");
    chk("filter_pass_lit", 64'(pass_count), 64'd2);
    chk("filter_drop_lit", 64'(drop_count), 64'd2);
    promiscuous = 1'b1;
    for (int i = 0; i < 3; i++) begin
      make_frame(dests[i], 60);
      send_frame(60, 60, 1'b0);
      drain();
    end
    promiscuous = 1'b0;
    check_counts("promisc");
    chk("promisc_pass_lit", 64'(pass_count), 64'd5);

    // Runt, then exact 6-byte broadcast carrying tuser.
    make_frame(BCAST, 4);
    send_frame(4, 4, 1'b0);
    drain();
    chk("runt_drop_lit", 64'(drop_count), 64'd3);
    make_frame(BCAST, 6);
    send_frame(6, 6, 1'b1);
    drain();
    check_counts("six_byte");
    chk("six_byte_pass_lit", 64'(pass_count), 64'd6);

    // Backpressure on a 100-byte matching frame.
    bp_mode = 1'b1;
    make_frame(LOCAL, 100);
    send_frame(100, 100, 1'b0);
    drain();
    bp_mode = 1'b0;
    @(posedge clk);
    #1;
    check_counts("backpressure");

    // Reset after byte 20 of a passing frame.
    make_frame(LOCAL, 64);
    send_frame(64, 20, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midreset_s_tready", {63'd0, s_tready}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    expq.delete();
    mdl_pass = 0;
    mdl_drop = 0;
    #1;
    chk("midreset_counts", {32'd0, pass_count, drop_count}, 64'd0);
    chk("midreset_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    @(posedge clk);
    #1;
    make_frame(OTHER, 30);
    send_frame(30, 30, 1'b0);
    make_frame(LOCAL, 30);
    send_frame(30, 30, 1'b0);
    drain();
    check_counts("after_reset");

    // Saturation of the 2-bit instance: 5 rejected frames since reset.
    for (int i = 0; i < 4; i++) begin
      make_frame(OTHER, 10 + i);
      send_frame(10 + i, 10 + i, 1'b0);
    end
    drain();
    check_counts("saturate");
    chk("saturate_drop_lit", 64'(drop_count), 64'd5);
    chk("saturate_sat_drop_lit", 64'(sat_drop), 64'd3);

    // Randomized back-to-back traffic with gaps, backpressure and config changes.
    gap_mode = 1'b1;
    bp_mode  = 1'b1;
    scramble = 1'b1;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 3) == 0)
        mac_addr = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
      promiscuous      = ($urandom_range(0, 3) == 0);
      accept_multicast = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = mac_addr;
        1: d = BCAST;
        2: d = {8'h01, 8'h00, 8'h5E, 24'($urandom)};
        default: d = {8'($urandom) & 8'hFE, 8'($urandom), 32'($urandom)};
      endcase
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 80));
      make_frame(d, len);
      send_frame(len, len, 1'($urandom_range(0, 1)));
    end
    drain();
    bp_mode = 1'b0;
    @(posedge clk);
    #1;
    check_counts("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
